fd_stage_reg: RTL and testbench
===============================

# fd_stage_reg

Fetch-to-decode pipeline register for the P7 MIPS core. It sits directly downstream of the fetch unit and captures the fetched PC and instruction each cycle. It also detects fetch-stage address exceptions (AdEL) and records the branch-delay-slot flag for the instruction entering D. It honours stall, handler-entry flush (Req) and reset, and presents registered D-stage values to the decoder, hazard unit and CP0 exception pipeline.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, PcD value after reset
- PC_HANDLER, 32'h0000_4180, PcD value after Req flush
- TEXT_LO, 32'h0000_3000, lowest legal fetch address
- TEXT_HI, 32'h0000_6FFC, highest legal fetch address (inclusive)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; highest priority
- Req  in  1  exception/interrupt entry; flushes D, second priority
- stall  in  1  hazard-unit stall; holds all D state
- PcF  in  32  PC of instruction in F (already EPC-muxed on eret)
- InstrF  in  32  instruction word read from IM at PcF
- BDF  in  1  instruction in F is a delay slot (D holds a branch/jump)
- PcD  out  32  registered PC for D
- InstrD  out  32  registered instruction for D (0 = nop when faulted or flushed)
- ExcCodeD  out  5  fetch exception code carried to D (0 none, 4 AdEL)
- BDD  out  1  registered delay-slot flag
- ValidD  out  1  D holds a real fetched instruction (not a reset/flush bubble)

## Operation
- Fetch check, combinational on F inputs: fault = (PcF[1:0] != 0) || (PcF < TEXT_LO) || (PcF > TEXT_HI). Comparisons are unsigned, 32-bit.
- Per-edge update priority: reset > Req > stall > load.
  - reset: PcD=PC_RESET, InstrD=0, ExcCodeD=0, BDD=0, ValidD=0.
  - Req (regardless of stall): PcD=PC_HANDLER, InstrD=0, ExcCodeD=0, BDD=0, ValidD=0.
  - stall (no reset/Req): every output holds its value.
  - load, no fault: PcD=PcF, InstrD=InstrF, ExcCodeD=0, BDD=BDF, ValidD=1.
  - load, fault: PcD=PcF (faulting address, for BadVAddr/EPC), InstrD=0, ExcCodeD=5'd4, BDD=BDF, ValidD=1.
- BDD is captured even for faulting instructions, so CP0 sets Cause.BD and EPC=PcD-4 correctly.
- An eret in D needs no flush here: the fetch unit already redirects PcF to EPC in that cycle, so the register loads normally.
- No combinational path from any input to any output.

## Timing
- Latency 1 cycle: the F values at edge n appear on the outputs after edge n.
- Outputs change only at rising clk edges. A stall of k cycles holds outputs for k edges; the F values present on the first unstalled edge are loaded.
- Req and stall asserted together: the flush wins on that edge, and the held instruction is discarded.
- reset asserted mid-stall or mid-Req: the reset values win on that edge.
- Reset values of outputs: PcD=0x00003000, InstrD=0, ExcCodeD=0, BDD=0, ValidD=0.
- Boundaries:
  - PcF=TEXT_HI (0x6FFC) is legal.
  - 0x7000 faults.
  - 0x2FFC faults.
  - 0x3002 faults on misalignment.
  - 0xFFFF_FFFC faults; no wrap-around to legal.

## Test plan
- Reset: hold reset 2 cycles with PcF=0x3010, InstrF=0x24080001 -> PcD=0x3000, InstrD=0, ValidD=0, ExcCodeD=0. Next edge without reset -> PcD=0x3010, InstrD=0x24080001, ValidD=1.
- Stall: load PcF=0x3004, then stall 3 cycles while PcF/InstrF change -> outputs frozen at 0x3004 for 3 edges. Release -> the current PcF is loaded on the next edge.
- Flush priority: Req=1 with stall=1 and PcF=0x3020 -> PcD=0x4180, InstrD=0, BDD=0, ValidD=0. Same edge with reset=1 -> PcD=0x3000.
- AdEL misaligned: PcF=0x3006, BDF=1 -> PcD=0x3006, InstrD=0, ExcCodeD=4, BDD=1, ValidD=1.
- Range boundaries: PcF=0x6FFC -> ExcCodeD=0. PcF=0x7000 -> 4. PcF=0x2FFC -> 4. PcF=0xFFFFFFFC -> 4.
- Delay slot: a jal in D drives BDF=1 while PcF=0x3008 -> BDD=1 with PcD=0x3008. Next non-slot instruction -> BDD=0.

Source files
------------

// File: rtl/fd_stage_reg_if.sv
// fd_stage_reg_if: F-to-D bus between the fetch unit, the F/D pipeline
// register and its D-stage consumers.
//   Req, stall          : flush and hold controls from CP0 / hazard unit
//   PcF, InstrF, BDF    : fetched PC, instruction word and delay-slot flag
//   PcD, InstrD, BDD    : registered D-stage PC, instruction and slot flag
//   ExcCodeD, ValidD    : fetch exception code and real-instruction flag
// master drives the F side and observes D; slave is the pipeline register.
interface fd_stage_reg_if;
  logic        Req;
  logic        stall;
  logic [31:0] PcF;
  logic [31:0] InstrF;
  logic        BDF;
  logic [31:0] PcD;
  logic [31:0] InstrD;
  logic [4:0]  ExcCodeD;
  logic        BDD;
  logic        ValidD;

  modport master (
    output Req, stall, PcF, InstrF, BDF,
    input  PcD, InstrD, ExcCodeD, BDD, ValidD
  );

  modport slave (
    input  Req, stall, PcF, InstrF, BDF,
    output PcD, InstrD, ExcCodeD, BDD, ValidD
  );
endinterface

// File: rtl/fd_stage_reg.sv
// fd_stage_reg: fetch-to-decode pipeline register of the P7 MIPS core.
// Captures PC, instruction and delay-slot flag from F, flags fetch address
// errors (AdEL) and presents purely registered values to D.
//   clk   : core clock, all updates on the rising edge
//   reset : synchronous, active-high, highest priority
//   fd    : slave side of fd_stage_reg_if (Req, stall, F inputs, D outputs)
// Edge priority: reset > Req > stall > load.
module fd_stage_reg #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] PC_HANDLER = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
  input  logic           clk,
  input  logic           reset,
  fd_stage_reg_if.slave  fd
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Unsigned 32-bit checks, so addresses near 0xFFFF_FFFC never wrap to legal.
  function automatic logic fetch_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
  endfunction

  logic        fault_s;
  logic [31:0] load_instr_s;
  logic [4:0]  load_exc_s;

  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [4:0]  exc_r;
  logic        bd_r;
  logic        valid_r;

  // Fetch address check and the instruction/exception values a load would take.
  always_comb begin
    fault_s      = fetch_fault(fd.PcF);
    load_instr_s = 32'h0000_0000;
    load_exc_s   = EXC_NONE;
    if (fault_s) begin
      // Faulting fetch enters D as a nop; the PC is kept for BadVAddr/EPC.
      load_instr_s = 32'h0000_0000;
      load_exc_s   = EXC_ADEL;
    end else begin
      load_instr_s = fd.InstrF;
      load_exc_s   = EXC_NONE;
    end
  end

  // D-stage state register with reset > Req > stall > load priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r    <= PC_RESET;
      instr_r <= 32'h0000_0000;
      exc_r   <= EXC_NONE;
      bd_r    <= 1'b0;
      valid_r <= 1'b0;
    end else if (fd.Req) begin
      // Handler entry discards whatever D held, even while stalled.
      pc_r    <= PC_HANDLER;
      instr_r <= 32'h0000_0000;
      exc_r   <= EXC_NONE;
      bd_r    <= 1'b0;
      valid_r <= 1'b0;
    end else if (fd.stall) begin
      pc_r    <= pc_r;
      instr_r <= instr_r;
      exc_r   <= exc_r;
      bd_r    <= bd_r;
      valid_r <= valid_r;
    end else begin
      // BDF is captured even on a fault so CP0 gets Cause.BD right.
      pc_r    <= fd.PcF;
      instr_r <= load_instr_s;
      exc_r   <= load_exc_s;
      bd_r    <= fd.BDF;
      valid_r <= 1'b1;
    end
  end

  assign fd.PcD      = pc_r;
  assign fd.InstrD   = instr_r;
  assign fd.ExcCodeD = exc_r;
  assign fd.BDD      = bd_r;
  assign fd.ValidD   = valid_r;

endmodule

// File: tb/tb_fd_stage_reg.sv
// tb_fd_stage_reg: directed test-plan sequences followed by randomized
// traffic, all compared against a behavioural model of the D-stage state.
module tb_fd_stage_reg;

  logic clk;
  logic reset;

  fd_stage_reg_if bus ();

  fd_stage_reg dut (
    .clk   (clk),
    .reset (reset),
    .fd    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model of what D should hold.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [4:0]  m_exc;
  logic        m_bd;
  logic        m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".PcD"},      bus.PcD,             m_pc);
    check({tag, ".InstrD"},   bus.InstrD,          m_instr);
    check({tag, ".ExcCodeD"}, {27'd0, bus.ExcCodeD}, {27'd0, m_exc});
    check({tag, ".BDD"},      {31'd0, bus.BDD},    {31'd0, m_bd});
    check({tag, ".ValidD"},   {31'd0, bus.ValidD}, {31'd0, m_valid});
  endtask

  // Legal fetch: word aligned and inside 0x3000..0x6FFC.
  function automatic bit is_legal(input logic [31:0] pc);
    longint unsigned a;
    a = pc;
    return (a % 4 == 0) && (a >= 64'h3000) && (a <= 64'h6FFC);
  endfunction

  // Advance the model by one clock edge given the inputs present at it.
  task automatic model_edge(input bit r, input bit q, input bit s,
                            input logic [31:0] pc, input logic [31:0] ins, input bit bd);
    if (r) begin
      m_pc = 32'h3000; m_instr = 32'h0; m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0;
    end else if (q) begin
      m_pc = 32'h4180; m_instr = 32'h0; m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0;
    end else if (!s) begin
      m_pc    = pc;
      m_instr = is_legal(pc) ? ins : 32'h0;
      m_exc   = is_legal(pc) ? 5'd0 : 5'd4;
      m_bd    = bd;
      m_valid = 1'b1;
    end
  endtask

  // One cycle: drive at negedge, confirm no input-to-output path, clock,
  // then compare at the next negedge.
  task automatic cycle(input string tag, input bit r, input bit q, input bit s,
                       input logic [31:0] pc, input logic [31:0] ins, input bit bd,
                       input bit check_hold);
    reset     = r;
    bus.Req   = q;
    bus.stall = s;
    bus.PcF   = pc;
    bus.InstrF = ins;
    bus.BDF   = bd;
    #1;
    if (check_hold) check({tag, ".nocomb"}, bus.PcD, m_pc);
    @(posedge clk);
    model_edge(r, q, s, pc, ins, bd);
    @(negedge clk);
    check_all(tag);
  endtask

  logic [31:0] bounds [0:6];

  initial begin
    bounds[0] = 32'h0000_6FFC; bounds[1] = 32'h0000_7000;
    bounds[2] = 32'h0000_2FFC; bounds[3] = 32'h0000_3002;
    bounds[4] = 32'hFFFF_FFFC; bounds[5] = 32'h0000_3000;
    bounds[6] = 32'h0000_0000;

    reset = 1'b1; bus.Req = 1'b0; bus.stall = 1'b0;
    bus.PcF = 32'h3010; bus.InstrF = 32'h2408_0001; bus.BDF = 1'b0;
    m_pc = 32'h3000; m_instr = 32'h0; m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0;
    @(negedge clk);

    // Reset held two cycles, then first load.
    cycle("rst0", 1'b1, 1'b0, 1'b0, 32'h3010, 32'h2408_0001, 1'b0, 1'b0);
    cycle("rst1", 1'b1, 1'b0, 1'b0, 32'h3010, 32'h2408_0001, 1'b0, 1'b1);
    check("rst_pc_const", bus.PcD, 32'h0000_3000);
    cycle("load0", 1'b0, 1'b0, 1'b0, 32'h3010, 32'h2408_0001, 1'b0, 1'b1);
    check("load0_instr_const", bus.InstrD, 32'h2408_0001);

    // Stall for three edges while F changes, then release.
    cycle("ld3004", 1'b0, 1'b0, 1'b0, 32'h3004, 32'h1111_1111, 1'b0, 1'b1);
    cycle("stall1", 1'b0, 1'b0, 1'b1, 32'h3008, 32'h2222_2222, 1'b1, 1'b1);
    cycle("stall2", 1'b0, 1'b0, 1'b1, 32'h300C, 32'h3333_3333, 1'b0, 1'b1);
    cycle("stall3", 1'b0, 1'b0, 1'b1, 32'h7000, 32'h4444_4444, 1'b1, 1'b1);
    check("stall_pc_const", bus.PcD, 32'h0000_3004);
    cycle("release", 1'b0, 1'b0, 1'b0, 32'h3030, 32'h5555_5555, 1'b0, 1'b1);

    // Flush wins over stall; reset wins over both.
    cycle("req_stall", 1'b0, 1'b1, 1'b1, 32'h3020, 32'h6666_6666, 1'b1, 1'b1);
    check("req_pc_const", bus.PcD, 32'h0000_4180);
    cycle("ld_after_req", 1'b0, 1'b0, 1'b0, 32'h4180, 32'h7777_7777, 1'b0, 1'b1);
    cycle("rst_req_stall", 1'b1, 1'b1, 1'b1, 32'h3020, 32'h6666_6666, 1'b1, 1'b1);

    // Misaligned fetch in a delay slot.
    cycle("adel_mis", 1'b0, 1'b0, 1'b0, 32'h3006, 32'h8888_8888, 1'b1, 1'b1);
    check("adel_exc_const", {27'd0, bus.ExcCodeD}, 32'd4);

    // Range boundaries.
    for (int i = 0; i < 7; i++) begin
      cycle($sformatf("bound%0d", i), 1'b0, 1'b0, 1'b0, bounds[i], 32'hA5A5_0000 + i, i[0], 1'b1);
    end

    // Delay slot flag follows BDF.
    cycle("slot", 1'b0, 1'b0, 1'b0, 32'h3008, 32'h0000_0000, 1'b1, 1'b1);
    check("slot_bd_const", {31'd0, bus.BDD}, 32'd1);
    cycle("noslot", 1'b0, 1'b0, 1'b0, 32'h300C, 32'h2409_0002, 1'b0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      bit r, q, s;
      r = ($urandom_range(0, 29) == 0);
      q = ($urandom_range(0, 11) == 0);
      s = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: pc = bounds[$urandom_range(0, 6)];
        1: pc = 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
        2: pc = 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2) + $urandom_range(1, 3);
        3: pc = $urandom;
        4: pc = $urandom_range(0, 32'h2FFF);
        default: pc = 32'h7000 + $urandom_range(0, 32'hFFFF);
      endcase
      cycle("rnd", r, q, s, pc, $urandom, $urandom_range(0, 1), 1'b1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
